// File: rtl/min_max_top.sv
// min_max_top: registered bar-graph LED driver for a min/max range display.
// Build option: define MIN_MAX_ERRINJ_EN to compile in the ERRNO faulty variants;
// without it ERRNO is ignored and the block always behaves correctly.
module min_max_top #(
    parameter int VALSIZE = 4,
    parameter int ERRNO   = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [1:0]            com_i,
    input  logic [VALSIZE-1:0]    min_i,
    input  logic [VALSIZE-1:0]    max_i,
    input  logic                  osc_i,
    input  logic [VALSIZE-1:0]    val_i,
    output logic [2**VALSIZE-1:0] leds_o
);
    localparam int LEDS = 2**VALSIZE;
`ifdef MIN_MAX_ERRINJ_EN
    localparam int ERR = ERRNO;
`else
    localparam int ERR = 0;
`endif

    logic [LEDS-1:0]    leds_d, leds_q;
    logic [VALSIZE-1:0] idx;
    logic               in_range;
    logic               osc_eff;

    // Next LED vector: min..val steady, val..max follows the oscillator, plus linear/off/on modes
    always_comb begin
        leds_d   = '0;
        idx      = '0;
        in_range = (min_i <= val_i) && (val_i <= max_i);
        osc_eff  = (ERR == 1) ? 1'b0 : osc_i;
        for (int i = 0; i < LEDS; i++) begin
            idx       = VALSIZE'(i);
            leds_d[i] = (com_i == 2'b11) ? !(ERR == 3 && i == 0) :
                        (com_i == 2'b01) ? ((ERR == 2) ? (idx < val_i) : (idx <= val_i)) :
                        (com_i == 2'b00) ? (in_range && idx >= min_i &&
                                            (idx <= val_i || (idx <= max_i && osc_eff))) :
                        1'b0;
        end
    end

    // Output register, cleared asynchronously by reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) leds_q <= '0;
        else         leds_q <= leds_d;
    end

    assign leds_o = leds_q;
endmodule

// File: tb/tb_min_max_top.sv
// tb_min_max_top: directed-vector scoreboard bench for min_max_top (VALSIZE=4).
module tb_min_max_top;
    typedef struct {
        logic [15:0] exp;
        string       name;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b1;
    logic [1:0]  com_i = 2'b10;
    logic [3:0]  min_i = '0;
    logic [3:0]  max_i = '0;
    logic        osc_i = 1'b0;
    logic [3:0]  val_i = '0;
    logic [15:0] leds_o;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    min_max_top #(.VALSIZE(4), .ERRNO(0)) dut (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .com_i (com_i),
        .min_i (min_i),
        .max_i (max_i),
        .osc_i (osc_i),
        .val_i (val_i),
        .leds_o(leds_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic apply(input string name, input logic [1:0] com, input logic [3:0] mn,
                         input logic [3:0] mx, input logic [3:0] vl, input logic osc,
                         input logic [15:0] exp);
        exp_t e;
        @(negedge clk_i);
        com_i = com; min_i = mn; max_i = mx; val_i = vl; osc_i = osc;
        e.exp = exp; e.name = name;
        q.push_back(e);
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && q.size() != 0; k++) @(posedge clk_i);
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain timeout got %0d pending want 0", q.size());
            q.delete();
        end
    endtask

    // Monitor: compare the registered output just after each rising edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_i);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                check(e.name, leds_o, e.exp);
            end
        end
    end

    initial begin
        #1 rst_ni = 1'b0;
        #1 check("reset_init", leds_o, 16'h0000);
        @(negedge clk_i);
        rst_ni = 1'b1;

        apply("norm_osc1",   2'b00, 4'd3,  4'd12, 4'd8,  1'b1, 16'h1FF8);
        apply("norm_osc0",   2'b00, 4'd3,  4'd12, 4'd8,  1'b0, 16'h01F8);
        apply("norm_tog1",   2'b00, 4'd3,  4'd12, 4'd8,  1'b1, 16'h1FF8);
        apply("norm_tog0",   2'b00, 4'd3,  4'd12, 4'd8,  1'b0, 16'h01F8);
        apply("below_min",   2'b00, 4'd3,  4'd12, 4'd2,  1'b1, 16'h0000);
        apply("above_max",   2'b00, 4'd3,  4'd12, 4'd13, 1'b1, 16'h0000);
        apply("min_gt_max",  2'b00, 4'd9,  4'd4,  4'd6,  1'b1, 16'h0000);
        apply("all_15",      2'b00, 4'd15, 4'd15, 4'd15, 1'b1, 16'h8000);
        apply("val_eq_max",  2'b00, 4'd4,  4'd10, 4'd10, 1'b0, 16'h07F0);
        apply("single_5",    2'b00, 4'd5,  4'd5,  4'd5,  1'b1, 16'h0020);
        apply("full_osc0",   2'b00, 4'd0,  4'd15, 4'd0,  1'b0, 16'h0001);
        apply("full_osc1",   2'b00, 4'd0,  4'd15, 4'd0,  1'b1, 16'hFFFF);
        apply("lin_5",       2'b01, 4'd9,  4'd2,  4'd5,  1'b1, 16'h003F);
        apply("lin_15",      2'b01, 4'd0,  4'd0,  4'd15, 1'b0, 16'hFFFF);
        apply("lin_0",       2'b01, 4'd7,  4'd9,  4'd0,  1'b1, 16'h0001);
        apply("all_on",      2'b11, 4'd9,  4'd4,  4'd6,  1'b0, 16'hFFFF);
        apply("all_off",     2'b10, 4'd3,  4'd12, 4'd8,  1'b1, 16'h0000);
        apply("pre_reset",   2'b11, 4'd0,  4'd0,  4'd0,  1'b0, 16'hFFFF);
        drain();

        @(posedge clk_i);
        #3 rst_ni = 1'b0;
        #1 check("reset_async", leds_o, 16'h0000);
        @(posedge clk_i);
        #1 check("reset_hold", leds_o, 16'h0000);
        @(negedge clk_i);
        rst_ni = 1'b1;
        begin
            exp_t e;
            e.exp = 16'hFFFF; e.name = "reset_release";
            q.push_back(e);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
